bus_arbiter: RTL and testbench

Grants ownership of the shared serial bus to one of MASTERS requesters so the interconnect steers control/wD/valid/last to one slave and rD/ready back.
Round-robin fairness, with priority for masters whose read was split by a slow slave.
Drives the interconnect mux selects and the per-master grant.
Revokes the bus on release, split or tenure timeout.

---
 rtl/bus_pkg.sv | 23 ++
 rtl/bus_arbiter_rr_pick.sv | 38 +++
 rtl/bus_arbiter.sv | 154 +++++++++++++++
 tb/tb_bus_arbiter.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// Shared types and constants for the serial-bus arbiter: FSM states, the
// "nobody" encodings for owner/slave IDs, and width helpers for the ID fields.
package bus_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } arb_state_t;

  localparam int NO_OWNER = 0;
  localparam int NO_SLAVE = 0;

  // ID fields reserve code 0 for "none", so n agents need room for n+1 codes.
  function automatic int id_width(input int n);
    return $clog2(n + 1);
  endfunction

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bus_arbiter_rr_pick.sv
// Combinational round-robin picker: returns the first set bit of `eligible`
// found by scanning upward from index `ptr`, wrapping around.
module rr_pick
  import bus_pkg::*;
#(
  parameter int N = 2,
  parameter int W = idx_width(N)
) (
  input  logic [N-1:0] eligible,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] winner,
  output logic         found
);

  logic [2*N-1:0] doubled;
  logic [N-1:0]   rotated;

  // Bit k of `rotated` is the request of master (ptr + k) mod N.
  assign doubled = {eligible, eligible} >> ptr;
  assign rotated = doubled[N-1:0];

  always_comb begin
    int sum;
    // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
    winner = '0;
    found  = 1'b0;
    sum    = 0;
    for (int k = 0; k < N; k++) begin
      if (!found && rotated[k]) begin
        sum = int'(ptr) + k;
        if (sum >= N) sum = sum - N;
        winner = W'(sum);
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Shared serial-bus arbiter: round-robin among masters with priority for
// masters whose read was split by a slow slave; revokes on release/split/timeout.
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int MASTERS    = 2,
  parameter int SLAVES     = 3,
  parameter int S_ID_WIDTH = id_width(SLAVES),
  parameter int M_ID_WIDTH = id_width(MASTERS),
  parameter int SPLIT_WAIT = 8,
  parameter int TIMEOUT    = 1024
) (
  input  logic                             clk,
  input  logic                             rstN,
  input  logic [MASTERS-1:0]               req,
  input  logic [MASTERS*S_ID_WIDTH-1:0]    m_slave_id,
  input  logic [SLAVES-1:0]                s_ready,
  output logic [MASTERS-1:0]               grant,
  output logic [M_ID_WIDTH-1:0]            grant_id,
  output logic [S_ID_WIDTH-1:0]            sel_slave,
  output logic [MASTERS-1:0]               split,
  output logic                             busy
);

  localparam int OW = idx_width(MASTERS);
  localparam int TW = $clog2(TIMEOUT);
  localparam int RW = $clog2(SPLIT_WAIT) + 1;

  localparam logic [S_ID_WIDTH-1:0] MAX_SLAVE   = S_ID_WIDTH'(SLAVES);
  localparam logic [S_ID_WIDTH-1:0] SLAVE_NONE  = S_ID_WIDTH'(NO_SLAVE);
  localparam logic [M_ID_WIDTH-1:0] OWNER_NONE  = M_ID_WIDTH'(NO_OWNER);
  localparam logic [OW-1:0]         LAST_IDX    = OW'(MASTERS - 1);
  localparam logic [TW-1:0]         TENURE_LAST = TW'(TIMEOUT - 1);
  localparam logic [RW-1:0]         LOW_LAST    = RW'(SPLIT_WAIT - 1);
  localparam logic [MASTERS-1:0]    ONE_HOT0    = MASTERS'(1);

  arb_state_t            state;
  logic [OW-1:0]         owner;
  logic [OW-1:0]         rr_ptr;
  logic [MASTERS-1:0]    split_pending;
  logic [S_ID_WIDTH-1:0] split_tgt [MASTERS];
  logic [TW-1:0]         tenure_cnt;
  logic [RW-1:0]         low_cnt;

  logic [(1<<S_ID_WIDTH)-1:0] ready_ext;
  logic [MASTERS-1:0]         eligible;
  logic [S_ID_WIDTH-1:0]      req_tgt [MASTERS];
  logic [OW-1:0]              sp_win, rr_win, win;
  logic                       sp_found, rr_found;
  logic [S_ID_WIDTH-1:0]      win_tgt;
  logic [M_ID_WIDTH-1:0]      win_id;
  logic                       ready_low, rel_drop, rel_split, rel_timeout, exit_grant;

  // Slave readiness indexed directly by slave ID; code 0 and unused codes read as not ready.
  always_comb begin
    ready_ext             = '0;
    ready_ext[SLAVES:1]   = s_ready;
  end

  for (genvar i = 0; i < MASTERS; i++) begin : g_elig
    logic [S_ID_WIDTH-1:0] id;
    assign id         = m_slave_id[i*S_ID_WIDTH +: S_ID_WIDTH];
    assign req_tgt[i] = split_pending[i] ? split_tgt[i] : id;
    assign eligible[i] = req[i] &&
                         (split_pending[i] ? ready_ext[split_tgt[i]]
                                           : (id != SLAVE_NONE && id <= MAX_SLAVE));
  end

  rr_pick #(.N(MASTERS), .W(OW)) u_pick_split (
    .eligible (eligible & split_pending),
    .ptr      (OW'(0)),
    .winner   (sp_win),
    .found    (sp_found)
  );

  rr_pick #(.N(MASTERS), .W(OW)) u_pick_rr (
    .eligible (eligible),
    .ptr      (rr_ptr),
    .winner   (rr_win),
    .found    (rr_found)
  );

  assign win     = sp_found ? sp_win : rr_win;
  assign win_tgt = req_tgt[win];
  assign win_id  = M_ID_WIDTH'(win) + M_ID_WIDTH'(1);

  // Tenure exit conditions, mutually exclusive in priority order.
  assign ready_low   = !ready_ext[sel_slave];
  assign rel_drop    = !req[owner];
  assign rel_split   = !rel_drop && ready_low && (low_cnt == LOW_LAST);
  assign rel_timeout = !rel_drop && !rel_split && (tenure_cnt == TENURE_LAST);
  assign exit_grant  = rel_drop || rel_split || rel_timeout;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state         <= IDLE;
      owner         <= '0;
      rr_ptr        <= '0;
      split_pending <= '0;
      tenure_cnt    <= '0;
      low_cnt       <= '0;
      grant         <= '0;
      grant_id      <= OWNER_NONE;
      sel_slave     <= SLAVE_NONE;
      split         <= '0;
      busy          <= 1'b0;
      // NOTE: the split-target array is tiny, so it is reset with the rest to keep X out of eligibility.
      for (int i = 0; i < MASTERS; i++) split_tgt[i] <= SLAVE_NONE;
    end else begin
      split <= '0;
      case (state)
        IDLE: begin
          if (rr_found) begin
            state      <= GRANT;
            owner      <= win;
            grant      <= ONE_HOT0 << win;
            grant_id   <= win_id;
            sel_slave  <= win_tgt;
            busy       <= 1'b1;
            tenure_cnt <= '0;
            low_cnt    <= '0;
          end
        end
        GRANT: begin
          if (exit_grant) begin
            state     <= RELEASE;
            grant     <= '0;
            grant_id  <= OWNER_NONE;
            sel_slave <= SLAVE_NONE;
          end else begin
            tenure_cnt <= tenure_cnt + TW'(1);
            low_cnt    <= ready_low ? low_cnt + RW'(1) : '0;
          end
          if (rel_drop) split_pending[owner] <= 1'b0;
          if (rel_split) begin
            split[owner]         <= 1'b1;
            split_pending[owner] <= 1'b1;
            split_tgt[owner]     <= sel_slave;
          end
        end
        RELEASE: begin
          state      <= IDLE;
          busy       <= 1'b0;
          rr_ptr     <= (owner == LAST_IDX) ? '0 : owner + OW'(1);
          tenure_cnt <= '0;
          low_cnt    <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: directed vector table, hand-written split/timeout/reset
// sequences, and randomized traffic checked every cycle against a tenure-level model.
module tb_bus_arbiter;

  localparam int M          = 2;
  localparam int S          = 3;
  localparam int SW         = 3;
  localparam int MW         = 2;
  localparam int SPLIT_WAIT = 8;
  localparam int TIMEOUT    = 16;

  logic            clk = 1'b0;
  logic            rstN = 1'b0;
  logic [M-1:0]    req = '0;
  logic [M*SW-1:0] m_slave_id = '0;
  logic [S-1:0]    s_ready = '1;
  logic [M-1:0]    grant;
  logic [MW-1:0]   grant_id;
  logic [SW-1:0]   sel_slave;
  logic [M-1:0]    split;
  logic            busy;

  always #5 clk = ~clk;

  bus_arbiter #(
    .MASTERS(M), .SLAVES(S), .S_ID_WIDTH(SW), .M_ID_WIDTH(MW),
    .SPLIT_WAIT(SPLIT_WAIT), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rstN(rstN), .req(req), .m_slave_id(m_slave_id), .s_ready(s_ready),
    .grant(grant), .grant_id(grant_id), .sel_slave(sel_slave), .split(split), .busy(busy)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cycle %0d: got %0h, want %0h", name, cyc, act, exp);
    end
  endtask

  // Reference model: tracks who owns the bus and how long, in plain cycle counts.
  int mo_owner, mo_last, mo_ptr, mo_held, mo_low, mo_sel, mo_split;
  bit mo_turn;
  bit mo_pend [M];
  int mo_tgt  [M];

  function automatic int id_of(input int i);
    return int'(m_slave_id[i*SW +: SW]);
  endfunction

  function automatic bit mo_elig(input int i);
    if (!req[i]) return 1'b0;
    if (mo_pend[i]) return s_ready[mo_tgt[i]-1];
    return (id_of(i) >= 1) && (id_of(i) <= S);
  endfunction

  task automatic model_reset();
    mo_owner = -1; mo_last = 0; mo_ptr = 0; mo_held = 0; mo_low = 0;
    mo_sel = 0; mo_split = -1; mo_turn = 1'b0;
    for (int i = 0; i < M; i++) begin mo_pend[i] = 1'b0; mo_tgt[i] = 0; end
  endtask

  task automatic model_step();
    int w;
    bit done;
    mo_split = -1;
    done = 1'b0;
    if (mo_owner >= 0) begin
      mo_held++;
      mo_low = s_ready[mo_sel-1] ? 0 : mo_low + 1;
      if (!req[mo_owner]) begin
        mo_pend[mo_owner] = 1'b0;
        done = 1'b1;
      end else if (mo_low == SPLIT_WAIT) begin
        mo_pend[mo_owner] = 1'b1;
        mo_tgt[mo_owner]  = mo_sel;
        mo_split = mo_owner;
        done = 1'b1;
      end else if (mo_held == TIMEOUT) begin
        done = 1'b1;
      end
      if (done) begin mo_last = mo_owner; mo_owner = -1; mo_turn = 1'b1; end
    end else if (mo_turn) begin
      mo_turn = 1'b0;
      mo_ptr  = (mo_last + 1) % M;
    end else begin
      w = -1;
      for (int i = 0; i < M; i++) if (w < 0 && mo_pend[i] && mo_elig(i)) w = i;
      for (int k = 0; k < M; k++) if (w < 0 && mo_elig((mo_ptr + k) % M)) w = (mo_ptr + k) % M;
      if (w >= 0) begin
        mo_owner = w;
        mo_sel   = mo_pend[w] ? mo_tgt[w] : id_of(w);
        mo_held  = 0;
        mo_low   = 0;
      end
    end
  endtask

  task automatic compare_model();
    check("model grant",     grant,     (mo_owner >= 0) ? (1 << mo_owner) : 0);
    check("model grant_id",  grant_id,  (mo_owner >= 0) ? mo_owner + 1 : 0);
    check("model sel_slave", sel_slave, (mo_owner >= 0) ? mo_sel : 0);
    check("model split",     split,     (mo_split >= 0) ? (1 << mo_split) : 0);
    check("model busy",      busy,      (mo_owner >= 0) || mo_turn);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    cyc++;
    #1;
    compare_model();
  endtask

  task automatic do_reset();
    rstN = 1'b0;
    req = '0; m_slave_id = '0; s_ready = '1;
    @(posedge clk);
    @(posedge clk);
    model_reset();
    @(negedge clk);
    rstN = 1'b1;
  endtask

  task automatic set_ids(input int id0, input int id1);
    m_slave_id = {SW'(id1), SW'(id0)};
  endtask

  typedef struct {
    logic [M-1:0]  req;
    int            id0, id1;
    logic [S-1:0]  rdy;
    logic [M-1:0]  g;
    logic [MW-1:0] gid;
    logic [SW-1:0] sel;
    logic          busy;
  } vec_t;

  vec_t tbl [21];

  initial begin
    tbl[0]  = '{2'b01, 1, 1, 3'b111, 2'b01, 2'd1, 3'd1, 1'b1};
    tbl[1]  = '{2'b01, 1, 1, 3'b111, 2'b01, 2'd1, 3'd1, 1'b1};
    tbl[2]  = '{2'b00, 1, 1, 3'b111, 2'b00, 2'd0, 3'd0, 1'b1};
    tbl[3]  = '{2'b00, 1, 1, 3'b111, 2'b00, 2'd0, 3'd0, 1'b0};
    tbl[4]  = '{2'b11, 2, 3, 3'b111, 2'b10, 2'd2, 3'd3, 1'b1};
    tbl[5]  = '{2'b11, 2, 3, 3'b111, 2'b10, 2'd2, 3'd3, 1'b1};
    tbl[6]  = '{2'b01, 2, 3, 3'b111, 2'b00, 2'd0, 3'd0, 1'b1};
    tbl[7]  = '{2'b01, 2, 3, 3'b111, 2'b00, 2'd0, 3'd0, 1'b0};
    tbl[8]  = '{2'b01, 2, 3, 3'b111, 2'b01, 2'd1, 3'd2, 1'b1};
    tbl[9]  = '{2'b11, 2, 3, 3'b111, 2'b01, 2'd1, 3'd2, 1'b1};
    tbl[10] = '{2'b10, 2, 3, 3'b111, 2'b00, 2'd0, 3'd0, 1'b1};
    tbl[11] = '{2'b10, 2, 3, 3'b111, 2'b00, 2'd0, 3'd0, 1'b0};
    tbl[12] = '{2'b10, 2, 3, 3'b111, 2'b10, 2'd2, 3'd3, 1'b1};
    tbl[13] = '{2'b00, 2, 3, 3'b111, 2'b00, 2'd0, 3'd0, 1'b1};
    tbl[14] = '{2'b00, 2, 3, 3'b111, 2'b00, 2'd0, 3'd0, 1'b0};
    tbl[15] = '{2'b01, 0, 0, 3'b111, 2'b00, 2'd0, 3'd0, 1'b0};
    tbl[16] = '{2'b01, 4, 0, 3'b111, 2'b00, 2'd0, 3'd0, 1'b0};
    tbl[17] = '{2'b11, 7, 0, 3'b111, 2'b00, 2'd0, 3'd0, 1'b0};
    tbl[18] = '{2'b11, 4, 2, 3'b111, 2'b10, 2'd2, 3'd2, 1'b1};
    tbl[19] = '{2'b00, 4, 2, 3'b111, 2'b00, 2'd0, 3'd0, 1'b1};
    tbl[20] = '{2'b00, 4, 2, 3'b111, 2'b00, 2'd0, 3'd0, 1'b0};

    // Reset state, before any clock edge has been taken out of reset.
    do_reset();
    check("reset grant", grant, 0);
    check("reset grant_id", grant_id, 0);
    check("reset sel_slave", sel_slave, 0);
    check("reset split", split, 0);
    check("reset busy", busy, 0);

    // Directed table: latency, release gap, round-robin order, invalid targets.
    for (int r = 0; r < 21; r++) begin
      req = tbl[r].req; set_ids(tbl[r].id0, tbl[r].id1); s_ready = tbl[r].rdy;
      cycle();
      check($sformatf("tbl[%0d] grant", r), grant, tbl[r].g);
      check($sformatf("tbl[%0d] grant_id", r), grant_id, tbl[r].gid);
      check($sformatf("tbl[%0d] sel_slave", r), sel_slave, tbl[r].sel);
      check($sformatf("tbl[%0d] busy", r), busy, tbl[r].busy);
    end

    // Split: slave 2 stalls for SPLIT_WAIT cycles, then master 0 regains priority.
    do_reset();
    req = 2'b01; set_ids(2, 1); s_ready = 3'b101;
    cycle();
    check("split first grant", grant, 2'b01);
    check("split first sel", sel_slave, 2);
    for (int k = 0; k < SPLIT_WAIT - 1; k++) begin
      cycle();
      check("split hold grant", grant, 2'b01);
      check("split hold no pulse", split, 0);
    end
    cycle();
    check("split pulse", split, 2'b01);
    check("split revoke grant", grant, 0);
    check("split release busy", busy, 1);
    cycle();
    check("split pulse once", split, 0);
    check("split idle busy", busy, 0);
    for (int k = 0; k < 2; k++) begin
      cycle();
      check("split target stalled", grant, 0);
    end
    req = 2'b11; s_ready = 3'b111;
    cycle();
    check("split priority grant", grant, 2'b01);
    check("split priority sel", sel_slave, 2);
    req = 2'b10;
    cycle(); cycle(); cycle();
    check("after split m1 grant", grant, 2'b10);
    check("after split m1 sel", sel_slave, 1);
    req = 2'b00;
    cycle(); cycle();

    // Tenure timeout: master 1 holds the bus for exactly TIMEOUT cycles.
    do_reset();
    req = 2'b10; set_ids(3, 1); s_ready = 3'b111;
    cycle();
    check("timeout first grant", grant, 2'b10);
    req = 2'b11;
    for (int k = 0; k < TIMEOUT - 1; k++) begin
      cycle();
      check("timeout hold grant", grant, 2'b10);
    end
    cycle();
    check("timeout revoke grant", grant, 0);
    check("timeout no split", split, 0);
    cycle();
    cycle();
    check("timeout next owner", grant, 2'b01);
    check("timeout next sel", sel_slave, 3);
    req = 2'b00;
    cycle(); cycle();

    // Asynchronous reset in the middle of a tenure.
    do_reset();
    req = 2'b01; set_ids(1, 2); s_ready = 3'b111;
    cycle();
    req = 2'b00;
    cycle(); cycle();
    req = 2'b10;
    cycle();
    check("pre-reset grant", grant, 2'b10);
    cycle();
    #2;
    rstN = 1'b0;
    #1;
    check("async reset grant", grant, 0);
    check("async reset grant_id", grant_id, 0);
    check("async reset sel_slave", sel_slave, 0);
    check("async reset split", split, 0);
    check("async reset busy", busy, 0);
    do_reset();
    req = 2'b11; set_ids(1, 2);
    cycle();
    check("post-reset rr start", grant, 2'b01);
    req = 2'b00;
    cycle(); cycle();

    // Randomized traffic with sticky requests and ready lines.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < M; i++) begin
        if ($urandom_range(0, 11) == 0) req[i] = ~req[i];
        if (!req[i] && $urandom_range(0, 1) == 0)
          m_slave_id[i*SW +: SW] = ($urandom_range(0, 3) == 0) ? SW'($urandom_range(0, 7))
                                                               : SW'($urandom_range(1, 3));
      end
      for (int k = 0; k < S; k++)
        if ($urandom_range(0, 7) == 0) s_ready[k] = ~s_ready[k];
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
